// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab unit: divider FSM states,
// default operand width and the iteration-counter sizing helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // Bits needed to hold an iteration count of 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_datapath.sv
// Non-restoring divider datapath: A/Q/M registers, operand signs and the
// final sign correction of quotient and remainder.
module divider_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic signed [WIDTH:0] a_q;
    logic signed [WIDTH:0] m_q;
    logic [WIDTH-1:0]      q_q;
    logic                  q_neg;
    logic                  r_neg;

    logic [WIDTH-1:0]      dividend_abs;
    logic [WIDTH-1:0]      divisor_abs;
    logic signed [WIDTH:0] a_shift;
    logic signed [WIDTH:0] sum_or_diff;
    logic signed [WIDTH:0] a_fix;
    logic                  m_zero;
    logic [WIDTH-1:0]      q_signed;
    logic [WIDTH-1:0]      r_mag;

    // Magnitudes fit in WIDTH unsigned bits, so the most-negative operand
    // becomes 2^(WIDTH-1) rather than wrapping.
    always_comb begin
        dividend_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisor_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        a_shift      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        sum_or_diff  = a_q[WIDTH] ? (a_shift + m_q) : (a_shift - m_q);
        a_fix        = a_q[WIDTH] ? (a_q + m_q) : a_q;
        m_zero       = (m_q == '0);
        q_signed     = q_neg ? (~q_q + 1'b1) : q_q;
        // Divide-by-zero never iterates, so Q still holds |dividend|.
        r_mag        = m_zero ? q_q : a_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            a_q   <= '0;
            q_q   <= dividend_abs;
            m_q   <= {1'b0, divisor_abs};
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end else if (step) begin
            a_q <= sum_or_diff;
            q_q <= {q_q[WIDTH-2:0], ~sum_or_diff[WIDTH]};
        end else if (fix) begin
            a_q       <= a_fix;
            quotient  <= m_zero ? '1 : q_signed;
            remainder <= r_neg ? (~r_mag + 1'b1) : r_mag;
        end
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed non-restoring divider: controller FSM, iteration
// counter, start/busy/done handshake and exception flags.
module nonrestoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output div_state_t       dbg_state
);

    // Handshake: start is sampled only in IDLE; busy covers ITER and FIX;
    // done is high for exactly the DONE cycle, results valid from then on.
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             step;
    logic             fix;
    logic             dz_pend;
    logic             ovf_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? FIX : ITER;
            ITER: if (count == CNT_W'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load      = (state == IDLE) && start;
        step      = (state == ITER);
        fix       = (state == FIX);
        busy      = (state == ITER) || (state == FIX);
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (load) count <= CNT_LOAD;
        else if (step) count <= count - 1'b1;
    end

    // Exception conditions are captured at start and published at FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_pend     <= 1'b0;
            ovf_pend    <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (load) begin
            dz_pend     <= (divisor == '0);
            ovf_pend    <= (dividend == MOST_NEG) && (divisor == '1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (fix) begin
            div_by_zero <= dz_pend;
            overflow    <= ovf_pend;
        end
    end

    divider_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (WIDTH=8) with a result
// scoreboard fed by the driver and drained on each done pulse.
module tb_nonrestoring_divider;
    import arith_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    div_state_t   dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [2*W+1:0] exp_q[$];

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {quotient, remainder, div_by_zero, overflow}.
    function automatic logic [2*W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {8'hFF, a, 2'b10};
        if (sa == -128 && sb == -1) return {8'h80, 8'h00, 2'b01};
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {q, r, 2'b00};
    endfunction

    always @(posedge clk) begin
        logic [2*W+1:0] e;
        #1;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("quotient", 32'(quotient), 32'(e[2*W+1:W+2]));
                check("remainder", 32'(remainder), 32'(e[W+1:2]));
                check("div_by_zero", 32'(div_by_zero), 32'(e[1]));
                check("overflow", 32'(overflow), 32'(e[0]));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat);
        int edges;
        int busy_cnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom_range(0, 255));
        divisor  = W'($urandom_range(0, 255));
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
        end
        check("latency", 32'(edges), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int dc0;
        int edges;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 9);
        run_op(8'h9C, 8'd7, 9);
        run_op(8'd100, 8'hF9, 9);
        run_op(8'h9C, 8'hF9, 9);
        run_op(8'h80, 8'hFF, 9);
        run_op(8'h80, 8'd1, 9);
        run_op(8'd3, 8'd5, 9);
        run_op(8'd5, 8'd0, 1);
        run_op(8'd9, 8'd3, 9);
        run_op(8'hFB, 8'd0, 1);
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            run_op(ra, rb, 9);
        end

        // Results stay put while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_quotient", 32'(quotient), 32'(model(ra, rb) >> (W + 2)));

        // start held high through the whole op with changing operands.
        dc0 = done_cnt;
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        exp_q.push_back(model(8'd50, 8'd5));
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            dividend = W'($urandom_range(0, 255));
            divisor  = W'($urandom_range(0, 255));
        end while (!done && edges < 40);
        check("hold_latency", 32'(edges), 32'd10);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("hold_one_done", 32'(done_cnt - dc0), 32'd1);
        run_op(8'd9, 8'd3, 9);

        // Asynchronous reset in the middle of ITER.
        @(negedge clk);
        dividend = 8'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("mid_state", 32'(dbg_state), 32'(ITER));
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_flags", 32'({div_by_zero, overflow}), 32'd0);
        dc0 = done_cnt;
        repeat (12) @(posedge clk);
        #1;
        check("arst_no_done", 32'(done_cnt - dc0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd127, 8'd2, 9);

        repeat (2) @(posedge clk);
        #2;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
